regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default WIDTH from all_pkgs (32), data bits per register.
REQ-002 SHALL have parameter NREGS, default 32, register count, power of two, >= 2.
REQ-003 SHALL have parameter NRD, default 2, number of read ports, >= 1.
REQ-004 SHALL have parameter NWR, default 2, number of write ports, >= 1.
REQ-005 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have ports: rst_n  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports: wr_en  in  NWR  per-port write enable.
REQ-008 SHALL have ports: wr_addr  in  NWR x log2(NREGS)  write addresses.
REQ-009 SHALL have ports: wr_data  in  NWR x WIDTH  write data.
REQ-010 SHALL have ports: rd_addr  in  NRD x log2(NREGS)  read addresses.
REQ-011 SHALL have ports: rd_data  out  NRD x WIDTH  read data.
REQ-012 SHALL have ports: rd_busy  out  NRD  pending-write flag for each read address.
REQ-013 SHALL have ports: sb_set_en, sb_set_addr  in  1, log2(NREGS)  mark register pending.
REQ-014 SHALL have ports: wr_conflict  out  1  sticky same-address multi-write flag.

Function
REQ-015 Reads SHALL be combinational from rd_addr; writes SHALL take effect on the rising clk edge.
REQ-016 Register 0 SHALL always read zero, SHALL ignore writes, and its busy bit SHALL never set.
REQ-017 Two or more write ports enabled to the same non-zero address in one cycle: highest-index port SHALL win.
REQ-018 The event in REQ-017 SHALL set wr_conflict on the next edge; wr_conflict SHALL hold until reset.
REQ-019 Scoreboard: one busy bit per register; sb_set_en SHALL set bit sb_set_addr on the next edge.
REQ-020 Any enabled write to address A SHALL clear busy bit A on the next edge.
REQ-021 sb_set and a write to the same address in one cycle: set SHALL win, so the bit ends at 1.
REQ-022 rd_busy[i] SHALL equal the stored busy bit of rd_addr[i], except as modified by REQ-027.
REQ-023 wr_en with wr_addr 0 SHALL be a no-op with no conflict contribution.
REQ-024 Address widths SHALL be $clog2(NREGS); no out-of-range address exists.

Reset
REQ-025 rst_n low at a rising edge SHALL zero all registers, all busy bits and wr_conflict.
REQ-026 Reset SHALL override same-cycle writes and sb_set; rd_data SHALL read zero in the first cycle after reset.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: a same-cycle enabled write to rd_addr[i] (non-zero) SHALL drive rd_data[i] with that write data, highest-index port winning, and SHALL force rd_busy[i] to 0 unless sb_set targets the same address.
REQ-028 REGFILE_BYPASS_EN undefined: rd_data and rd_busy SHALL reflect stored state only; new data SHALL be visible one cycle after the write.

Structure
REQ-029 The all_pkgs package SHALL hold WIDTH and the default NREGS/NRD/NWR constants.
REQ-030 The scoreboard SHALL be a sub-module regfile_scoreboard (busy bits, set/clear priority, NRD busy lookups); storage and bypass SHALL live in regfile_mp.

Verification
REQ-031 Reset, then read all addresses -> every rd_data = 0, rd_busy = 0, wr_conflict = 0.
REQ-032 Write 0xDEADBEEF to r5 via port 0, read r5 next cycle -> 0xDEADBEEF; write 0x1234 to r0 -> r0 reads 0.
REQ-033 Ports 0 and 1 both write r7 (0x11, 0x22) -> r7 = 0x22 and wr_conflict = 1, held through 10 idle cycles.
REQ-034 sb_set r9, then rd_busy for r9 = 1; later write r9 = 0x55 -> busy clears next cycle; set and write r9 in the same cycle -> busy stays 1.
REQ-035 With REGFILE_BYPASS_EN: write r3 = 0xA5A5 while reading r3 -> rd_data = 0xA5A5 in the same cycle; without the macro -> old value, then 0xA5A5 next cycle.
REQ-036 Assert rst_n low in a cycle with active writes and sb_set -> all state zero next cycle.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared constants for the multi-ported register file: data width and default geometry.
package all_pkgs;
  localparam int WIDTH   = 32;
  localparam int NREGS_D = 32;
  localparam int NRD_D   = 2;
  localparam int NWR_D   = 2;
endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: write ports, read ports, scoreboard set and conflict flag.
interface regfile_mp_if #(
  parameter int WIDTH = all_pkgs::WIDTH,
  parameter int NREGS = all_pkgs::NREGS_D,
  parameter int NRD   = all_pkgs::NRD_D,
  parameter int NWR   = all_pkgs::NWR_D
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]            wr_en;
  logic [NWR-1:0][AW-1:0]    wr_addr;
  logic [NWR-1:0][WIDTH-1:0] wr_data;
  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0][WIDTH-1:0] rd_data;
  logic [NRD-1:0]            rd_busy;
  logic                      sb_set_en;
  logic [AW-1:0]             sb_set_addr;
  logic                      wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, wr_conflict
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, wr_conflict
  );
endinterface

// File: rtl/regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set beats same-cycle clear.
module regfile_scoreboard #(
  parameter int NREGS = all_pkgs::NREGS_D,
  parameter int NRD   = all_pkgs::NRD_D,
  parameter int NWR   = all_pkgs::NWR_D,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NWR-1:0]         i_wr_en,
  input  logic [NWR-1:0][AW-1:0] i_wr_addr,
  input  logic                   i_sb_set_en,
  input  logic [AW-1:0]          i_sb_set_addr,
  input  logic [NRD-1:0][AW-1:0] i_rd_addr,
  output logic [NRD-1:0]         o_busy
);
  logic [NREGS-1:0] r_busy;

  // Clears first, set last, so a same-cycle set leaves the bit at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (i_wr_en[i]) r_busy[i_wr_addr[i]] <= 1'b0;
      if (i_sb_set_en && i_sb_set_addr != '0) r_busy[i_sb_set_addr] <= 1'b1;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int k = 0; k < NRD; k++) o_busy[k] = r_busy[i_rd_addr[k]];
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with r0 hardwired to zero, sticky write-conflict flag
// and pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp #(
  parameter int WIDTH = all_pkgs::WIDTH,
  parameter int NREGS = all_pkgs::NREGS_D,
  parameter int NRD   = all_pkgs::NRD_D,
  parameter int NWR   = all_pkgs::NWR_D
) (
  input logic        clk,
  input logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [NREGS-1:0][WIDTH-1:0] r_regs;
  logic                        r_wr_conflict;
  logic                        w_conflict;
  logic [NRD-1:0]              w_sb_busy;
  logic [NRD-1:0][WIDTH-1:0]   w_rd_data;
  logic [NRD-1:0]              w_rd_busy;

  regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .NWR(NWR)) u_sb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (bus.wr_en),
    .i_wr_addr     (bus.wr_addr),
    .i_sb_set_en   (bus.sb_set_en),
    .i_sb_set_addr (bus.sb_set_addr),
    .i_rd_addr     (bus.rd_addr),
    .o_busy        (w_sb_busy)
  );

  // Ascending port order: the last assignment (highest index) wins on a shared address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (bus.wr_en[i] && bus.wr_addr[i] != '0) r_regs[bus.wr_addr[i]] <= bus.wr_data[i];
    end
  end

  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NWR; i++)
      for (int j = i + 1; j < NWR; j++)
        if (bus.wr_en[i] && bus.wr_en[j] && bus.wr_addr[i] == bus.wr_addr[j] &&
            bus.wr_addr[i] != '0)
          w_conflict = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_wr_conflict <= 1'b0;
    else        r_wr_conflict <= r_wr_conflict | w_conflict;
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = w_sb_busy;
    for (int k = 0; k < NRD; k++) w_rd_data[k] = r_regs[bus.rd_addr[k]];
`ifdef REGFILE_BYPASS_EN
    // A bypassed read is no longer pending unless the same cycle re-marks it.
    for (int k = 0; k < NRD; k++)
      for (int i = 0; i < NWR; i++)
        if (bus.wr_en[i] && bus.wr_addr[i] == bus.rd_addr[k] && bus.wr_addr[i] != '0) begin
          w_rd_data[k] = bus.wr_data[i];
          w_rd_busy[k] = bus.sb_set_en && (bus.sb_set_addr == bus.rd_addr[k]);
        end
`endif
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.wr_conflict = r_wr_conflict;
endmodule
